// File: rtl/bitonic_batch_scheduler.sv
// Batch scheduler for bitonic_sort_16: gathers up to 16 pairs, pads with all-ones, sorts, drains.
// Optional WAIT-state watchdog is enabled by defining BITONIC_SCHED_WATCHDOG_EN.
module bitonic_batch_scheduler #(
    parameter int unsigned PAIR_W      = 64,  // $bits(tuple_pair_t)
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAIR_W-1:0]    in_pair,
    input  logic                 in_last,
    output logic                 sort_valid,
    output logic [16*PAIR_W-1:0] sort_pairs_flat,
    input  logic                 sort_done,
    input  logic [16*PAIR_W-1:0] sort_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAIR_W-1:0]    out_pair,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err
);

    localparam logic [2:0] StFill   = 3'd0;
    localparam logic [2:0] StIssue0 = 3'd1;
    localparam logic [2:0] StIssue1 = 3'd2;
    localparam logic [2:0] StWait   = 3'd3;
    localparam logic [2:0] StDrain  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [4:0]        count_q, count_d;
    logic [3:0]        idx_q, idx_d;
    logic              err_q, err_d;
    logic [PAIR_W-1:0] batch_q [16];
    logic              in_fire, out_fire, wd_timeout;

    // in_ready is gated by reset so every output reads 0 while reset is held.
    assign in_ready   = (state_q == StFill) && !reset;
    assign sort_valid = (state_q == StIssue0) || (state_q == StIssue1);
    assign out_valid  = (state_q == StDrain);
    assign out_pair   = out_valid ? batch_q[idx_q] : '0;
    assign out_last   = out_valid && ({1'b0, idx_q} == (count_q - 5'd1));
    assign busy       = (state_q != StFill) || (count_q != 5'd0);
    assign err        = err_q;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;

    always_comb begin
        sort_pairs_flat = '0;
        if (sort_valid) begin
            for (int i = 0; i < 16; i++) begin
                sort_pairs_flat[i*PAIR_W +: PAIR_W] =
                    (5'(i) < count_q) ? batch_q[i] : {PAIR_W{1'b1}};
            end
        end
    end

`ifdef BITONIC_SCHED_WATCHDOG_EN
    logic [7:0] wd_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
        end else if (state_q != StWait) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 8'd1;
        end
    end

    assign wd_timeout = (state_q == StWait) && (wd_q == 8'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign wd_timeout     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        // A sorter result outside WAIT is a protocol violation; its data is dropped.
        err_d   = err_q || (sort_done && (state_q != StWait));
        case (state_q)
            StFill: begin
                if (in_fire) begin
                    count_d = count_q + 5'd1;
                    if ((count_q == 5'd15) || in_last) begin
                        state_d = StIssue0;
                    end
                end
            end
            StIssue0: state_d = StIssue1;
            StIssue1: state_d = StWait;
            StWait: begin
                if (sort_done) begin
                    idx_d   = '0;
                    state_d = StDrain;
                end else if (wd_timeout) begin
                    err_d   = 1'b1;
                    count_d = '0;
                    state_d = StFill;
                end
            end
            StDrain: begin
                if (out_fire) begin
                    idx_d = idx_q + 4'd1;
                    if (out_last) begin
                        count_d = '0;
                        state_d = StFill;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StFill;
            count_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Batch storage needs no reset; it is always written before it is read.
    always_ff @(posedge clock) begin
        if (in_fire) begin
            batch_q[count_q[3:0]] <= in_pair;
        end else if ((state_q == StWait) && sort_done) begin
            for (int i = 0; i < 16; i++) begin
                batch_q[i] <= sort_result[i*PAIR_W +: PAIR_W];
            end
        end
    end

endmodule
